// File: rtl/windowed_reg_file.sv
// Windowed register file with 8 globals and NWIN overlapping 16-register windows.
// Two combinational read ports, one write port, and SAVE/RESTORE window control with traps.
module windowed_reg_file #(
    parameter int unsigned NWIN = 4
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic [4:0]               RA,
    input  logic [4:0]               RB,
    output logic [31:0]              PA,
    output logic [31:0]              PB,
    input  logic [4:0]               RC,
    input  logic [31:0]              PC,
    input  logic                     RFE,
    input  logic                     Save,
    input  logic                     Restore,
    input  logic [NWIN-1:0]          WIM,
    output logic [$clog2(NWIN)-1:0]  CWP,
    output logic                     WinOvf,
    output logic                     WinUnf
);

    localparam int unsigned CW    = $clog2(NWIN);
    localparam int unsigned NPHYS = 8 + 16 * NWIN;
    localparam int unsigned PW    = $clog2(NPHYS);

    typedef enum logic [1:0] {
        WOP_NONE,
        WOP_SAVE,
        WOP_RESTORE
    } wop_e;

    logic [31:0]   regs_q [NPHYS];
    logic [CW-1:0] cwp_q, cwp_d;
    logic [CW-1:0] cwp_dec, cwp_inc;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    wop_e          wop;
    logic [PW-1:0] ra_idx, rb_idx, wr_idx;

    // r8-r23 sit in the current window; r24-r31 alias the next window's r8-r15.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0]    r,
                                               input logic [CW-1:0] w_cur,
                                               input logic [CW-1:0] w_nxt);
        if (r < 5'd8)
            phys_idx = PW'(r);
        else if (r < 5'd24)
            phys_idx = PW'(32'd16 * 32'(w_cur) + 32'(r));
        else
            phys_idx = PW'(32'd16 * 32'(w_nxt) + 32'(r) - 32'd16);
    endfunction

    always_comb begin
        cwp_dec = (cwp_q == '0) ? CW'(NWIN - 1) : cwp_q - CW'(1);
        cwp_inc = (cwp_q == CW'(NWIN - 1)) ? '0 : cwp_q + CW'(1);
    end

    assign ra_idx = phys_idx(RA, cwp_q, cwp_inc);
    assign rb_idx = phys_idx(RB, cwp_q, cwp_inc);
    assign wr_idx = phys_idx(RC, cwp_q, cwp_inc);

    assign PA = (RA == '0) ? '0 : regs_q[ra_idx];
    assign PB = (RB == '0) ? '0 : regs_q[rb_idx];

    always_comb begin
        wop = WOP_NONE;
        if (Save && !Restore)
            wop = WOP_SAVE;
        else if (Restore && !Save)
            wop = WOP_RESTORE;
    end

    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        unique case (wop)
            WOP_SAVE: begin
                if (WIM[cwp_dec])
                    ovf_d = 1'b1;
                else
                    cwp_d = cwp_dec;
            end
            WOP_RESTORE: begin
                if (WIM[cwp_inc])
                    unf_d = 1'b1;
                else
                    cwp_d = cwp_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cwp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int unsigned i = 0; i < NPHYS; i++)
                regs_q[i] <= '0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (RFE && (RC != '0))
                regs_q[wr_idx] <= PC;
        end
    end

    assign CWP    = cwp_q;
    assign WinOvf = ovf_q;
    assign WinUnf = unf_q;

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed, table-driven bench for windowed_reg_file (NWIN=4), plus hand sequences for
// trap pulses and asynchronous reset during a pending write.
module tb_windowed_reg_file;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [4:0]  RA, RB, RC;
    logic [31:0] PA, PB, PC;
    logic        RFE, Save, Restore;
    logic [3:0]  WIM;
    logic [1:0]  CWP;
    logic        WinOvf, WinUnf;

    windowed_reg_file #(.NWIN(4)) dut (
        .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .PA(PA), .PB(PB),
        .RC(RC), .PC(PC), .RFE(RFE), .Save(Save), .Restore(Restore),
        .WIM(WIM), .CWP(CWP), .WinOvf(WinOvf), .WinUnf(WinUnf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  ra, rb, rc;
        logic [31:0] pc;
        logic        rfe, sv, rs;
        logic [3:0]  wim;
        logic [31:0] pa, pb;
        logic [1:0]  cwp;
        logic        ovf, unf;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic add(input int unsigned ra, input int unsigned rb, input int unsigned rc,
                       input logic [31:0] pc, input int unsigned rfe, input int unsigned sv,
                       input int unsigned rs, input int unsigned wim,
                       input logic [31:0] pa, input logic [31:0] pb, input int unsigned cwp,
                       input int unsigned ovf, input int unsigned unf);
        vec_t v;
        v.ra = 5'(ra); v.rb = 5'(rb); v.rc = 5'(rc); v.pc = pc;
        v.rfe = 1'(rfe); v.sv = 1'(sv); v.rs = 1'(rs); v.wim = 4'(wim);
        v.pa = pa; v.pb = pb; v.cwp = 2'(cwp); v.ovf = 1'(ovf); v.unf = 1'(unf);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] pa, input logic [31:0] pb,
                            input logic [1:0] cwp, input logic ovf, input logic unf);
        chk({tag, ".PA"}, PA, pa);
        chk({tag, ".PB"}, PB, pb);
        chk({tag, ".CWP"}, 32'(CWP), 32'(cwp));
        chk({tag, ".WinOvf"}, 32'(WinOvf), 32'(ovf));
        chk({tag, ".WinUnf"}, 32'(WinUnf), 32'(unf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //  ra  rb  rc  pc            rfe sv rs wim   pa            pb            cwp ovf unf
        add( 0,  0,  0, 32'h0,         0, 0, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add( 5,  0,  5, 32'hDEADBEEF,  1, 0, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add( 5,  0,  0, 32'h1234,      1, 0, 0, 0,    32'hDEADBEEF, 32'h0,        0, 0, 0);
        add( 5,  0,  0, 32'h0,         0, 0, 0, 0,    32'hDEADBEEF, 32'h0,        0, 0, 0);
        add( 8,  0,  8, 32'hA5A5A5A5,  1, 0, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add( 8, 24,  0, 32'h0,         0, 1, 0, 0,    32'hA5A5A5A5, 32'h0,        0, 0, 0);
        add(24,  8,  0, 32'h0,         0, 0, 1, 0,    32'hA5A5A5A5, 32'h0,        3, 0, 0);
        add( 8,  5,  0, 32'h0,         0, 0, 0, 0,    32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 1, 0, 8,    32'h0,        32'h0,        0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 0, 8,    32'h0,        32'h0,        0, 1, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 2,    32'h0,        32'h0,        0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 0, 2,    32'h0,        32'h0,        0, 0, 1);
        add( 0,  0,  0, 32'h0,         0, 1, 1, 0,    32'h0,        32'h0,        0, 0, 0);
        add(16,  0, 16, 32'h11,        1, 1, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add(16,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        3, 0, 0);
        add(16,  8,  0, 32'h0,         0, 0, 0, 0,    32'h11,       32'hA5A5A5A5, 0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        1, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        2, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        3, 0, 0);
        add( 8,  0,  0, 32'h0,         0, 0, 0, 0,    32'hA5A5A5A5, 32'h0,        0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 1, 0, 4,    32'h0,        32'h0,        0, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 1, 0, 4,    32'h0,        32'h0,        3, 0, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 1, 0,    32'h0,        32'h0,        3, 1, 0);
        add( 0,  0,  0, 32'h0,         0, 0, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add(31,  0, 31, 32'hCAFEF00D,  1, 0, 0, 0,    32'h0,        32'h0,        0, 0, 0);
        add(31, 15,  0, 32'h0,         0, 0, 1, 0,    32'hCAFEF00D, 32'h0,        0, 0, 0);
        add(15, 31,  0, 32'h0,         0, 0, 0, 0,    32'hCAFEF00D, 32'h0,        1, 0, 0);

        Clr = 1'b0; RA = '0; RB = '0; RC = '0; PC = '0;
        RFE = 1'b0; Save = 1'b0; Restore = 1'b0; WIM = '0;
        #2;
        chk_outs("reset0", 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        #10 Clr = 1'b1;
        @(posedge Clk); #1;

        foreach (vecs[i]) begin
            RA = vecs[i].ra; RB = vecs[i].rb; RC = vecs[i].rc; PC = vecs[i].pc;
            RFE = vecs[i].rfe; Save = vecs[i].sv; Restore = vecs[i].rs; WIM = vecs[i].wim;
            @(negedge Clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].pa, vecs[i].pb, vecs[i].cwp,
                     vecs[i].ovf, vecs[i].unf);
            @(posedge Clk); #1;
        end

        // CWP is 1 here; window 0 invalid makes this Save trap.
        RA = '0; RB = '0; RFE = 1'b0; Save = 1'b1; WIM = 4'b0001;
        @(posedge Clk); #1;
        chk("trap_before_rst.WinOvf", 32'(WinOvf), 32'd1);
        chk("trap_before_rst.CWP", 32'(CWP), 32'd1);

        Save = 1'b0; WIM = '0; RFE = 1'b1; RC = 5'd9; PC = 32'h77; RA = 5'd5; RB = 5'd15;
        #2 Clr = 1'b0;
        #1;
        chk("async_rst.CWP", 32'(CWP), 32'd0);
        chk("async_rst.WinOvf", 32'(WinOvf), 32'd0);
        chk("async_rst.WinUnf", 32'(WinUnf), 32'd0);
        chk("async_rst.PA_r5", PA, 32'h0);
        chk("async_rst.PB_r15", PB, 32'h0);

        Save = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hold.CWP", 32'(CWP), 32'd0);
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(31 - i);
            #1;
            chk($sformatf("rst_scan.PA_r%0d", i), PA, 32'h0);
            chk($sformatf("rst_scan.PB_r%0d", 31 - i), PB, 32'h0);
        end

        @(negedge Clk);
        Clr = 1'b1; RFE = 1'b0; Save = 1'b0; RA = 5'd9;
        @(posedge Clk); #1;
        chk("post_rst.PA_r9", PA, 32'h0);
        chk("post_rst.CWP", 32'(CWP), 32'd0);

        RFE = 1'b1; RC = 5'd9; PC = 32'h77;
        @(posedge Clk); #1;
        RFE = 1'b0;
        chk("resume.PA_r9", PA, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
